// File: rtl/pellet_draw_scheduler.sv
// pellet_draw_scheduler: holds the maze pellet map, animates the 5x5 pellet
// shape and streams every tile's 25 pixels to the VGA plotter.
// Optional feature macro: PELLET_ANIM_EN (shape animation). When undefined,
// frame_tick is ignored and every pass draws ANI_0.
module pellet_draw_scheduler #(
    parameter int          GRID_W        = 28,
    parameter int          GRID_H        = 31,
    parameter int          ANI_DIV       = 8,
    parameter logic [2:0]  PELLET_COLOUR = 3'b111
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    output logic       busy,
    output logic       done,
    input  logic       eat_valid,
    input  logic [4:0] eat_x,
    input  logic [4:0] eat_y,
    output logic       eat_ready,
    output logic [9:0] pellets_left,
    output logic       all_eaten,
    output logic       plot_valid,
    input  logic       plot_ready,
    output logic [7:0] plot_x,
    output logic [7:0] plot_y,
    output logic [2:0] plot_colour
);
    localparam int          NT    = GRID_W * GRID_H;
    localparam logic [24:0] ANI_0 = 25'b0000000110011100110000000;
    localparam logic [24:0] ANI_1 = 25'b0000001100011100011000000;
    localparam logic [4:0]  X_MAX = 5'(GRID_W - 1);
    localparam logic [4:0]  Y_MAX = 5'(GRID_H - 1);

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

    state_t      state, state_nxt;
    logic [NT-1:0] map, map_nxt;
    logic [24:0] shp, cur_shape, shape_sel;
    logic [4:0]  tx, ty, n_tx, n_ty;
    logic [2:0]  row, col, n_row, n_col;
    logic        start_acc, eat_acc, eat_hit, last, xfer, step;
    logic [9:0]  eat_idx, pix_idx;
    logic [4:0]  sbit;

`ifdef PELLET_ANIM_EN
    localparam int CW = (ANI_DIV > 1) ? $clog2(ANI_DIV) : 1;
    logic [CW-1:0] fcnt;
    logic          phase;

    // Frame counter: toggle the animation phase every ANI_DIV frame ticks.
    always_ff @(posedge clock) begin
        if (reset) begin
            fcnt  <= '0;
            phase <= 1'b0;
        end else if (frame_tick) begin
            if (fcnt == CW'(ANI_DIV - 1)) begin
                fcnt  <= '0;
                phase <= ~phase;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end
    assign cur_shape = phase ? ANI_1 : ANI_0;
`else
    logic unused_tick;
    assign unused_tick = frame_tick;
    assign cur_shape   = ANI_0;
`endif

    assign xfer      = plot_valid && plot_ready;
    assign last      = (tx == X_MAX) && (ty == Y_MAX) && (row == 3'd4) && (col == 3'd4);
    assign all_eaten = (pellets_left == 10'd0);

    // FSM next-state and handshake-facing status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        eat_ready = 1'b0;
        start_acc = 1'b0;
        step      = 1'b0;
        case (state)
            S_IDLE: begin
                eat_ready = 1'b1;
                if (start) begin
                    start_acc = 1'b1;
                    state_nxt = S_DRAW;
                end
            end
            S_DRAW: begin
                busy = 1'b1;
                step = xfer;
                if (xfer && last) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Map update from eat events, next pixel indices and pixel lookup.
    // The lookup uses map_nxt so an eat coincident with start is drawn erased.
    always_comb begin
        eat_acc = eat_valid && (state == S_IDLE);
        eat_idx = 10'(eat_y) * 10'(GRID_W) + 10'(eat_x);
        eat_hit = 1'b0;
        map_nxt = map;
        if (eat_acc && (eat_x <= X_MAX) && (eat_y <= Y_MAX) && map[eat_idx]) begin
            eat_hit          = 1'b1;
            map_nxt[eat_idx] = 1'b0;
        end

        n_tx  = tx;
        n_ty  = ty;
        n_row = row;
        n_col = col;
        if (start_acc) begin
            n_tx  = '0;
            n_ty  = '0;
            n_row = '0;
            n_col = '0;
        end else if (step && !last) begin
            if (col != 3'd4) begin
                n_col = col + 1'b1;
            end else begin
                n_col = '0;
                if (row != 3'd4) begin
                    n_row = row + 1'b1;
                end else begin
                    n_row = '0;
                    if (tx != X_MAX) begin
                        n_tx = tx + 1'b1;
                    end else begin
                        n_tx = '0;
                        n_ty = ty + 1'b1;
                    end
                end
            end
        end

        shape_sel = start_acc ? cur_shape : shp;
        pix_idx   = 10'(n_ty) * 10'(GRID_W) + 10'(n_tx);
        sbit      = 5'd24 - (5'(n_row) * 5'd5 + 5'(n_col));
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Map, pellet count, pixel walk and registered plotter outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            map          <= '1;
            pellets_left <= 10'(NT);
            shp          <= ANI_0;
            tx           <= '0;
            ty           <= '0;
            row          <= '0;
            col          <= '0;
            plot_valid   <= 1'b0;
            plot_x       <= '0;
            plot_y       <= '0;
            plot_colour  <= '0;
        end else begin
            map <= map_nxt;
            if (eat_hit && pellets_left != 10'd0) pellets_left <= pellets_left - 1'b1;
            if (start_acc) begin
                shp        <= cur_shape;
                plot_valid <= 1'b1;
            end
            if (start_acc || step) begin
                tx          <= n_tx;
                ty          <= n_ty;
                row         <= n_row;
                col         <= n_col;
                plot_x      <= 8'(n_tx) * 8'd5 + 8'(n_col);
                plot_y      <= 8'(n_ty) * 8'd5 + 8'(n_row);
                plot_colour <= (map_nxt[pix_idx] && shape_sel[sbit]) ? PELLET_COLOUR : 3'b000;
            end
            if (step && last) plot_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pellet_draw_scheduler.sv
// Self-checking bench for pellet_draw_scheduler (ANI_DIV=2 build).
module tb_pellet_draw_scheduler;
    localparam int W = 28, H = 31, NT = 868, NPIX = 21700;
    localparam logic [24:0] A0 = 25'b0000000110011100110000000;
    localparam logic [24:0] A1 = 25'b0000001100011100011000000;
`ifdef PELLET_ANIM_EN
    localparam bit ANIM = 1'b1;
`else
    localparam bit ANIM = 1'b0;
`endif

    logic clock = 0, reset = 1, frame_tick = 0, start = 0;
    logic busy, done, eat_valid = 0, eat_ready, all_eaten, plot_valid, plot_ready = 1;
    logic [4:0] eat_x = 0, eat_y = 0;
    logic [9:0] pellets_left;
    logic [7:0] plot_x, plot_y;
    logic [2:0] plot_colour;

    pellet_draw_scheduler #(.ANI_DIV(2)) dut (
        .clock(clock), .reset(reset), .frame_tick(frame_tick), .start(start),
        .busy(busy), .done(done), .eat_valid(eat_valid), .eat_x(eat_x), .eat_y(eat_y),
        .eat_ready(eat_ready), .pellets_left(pellets_left), .all_eaten(all_eaten),
        .plot_valid(plot_valid), .plot_ready(plot_ready), .plot_x(plot_x),
        .plot_y(plot_y), .plot_colour(plot_colour)
    );

    always #5 clock = ~clock;

    int total = 0, bad = 0;
    bit mdl [NT];
    logic [24:0] shp_exp;
    logic [18:0] got [NPIX];

    typedef struct { int x; int y; int left; } eat_vec_t;
    typedef struct { int idx; int x; int y; int c; } pix_vec_t;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic logic [18:0] exp_pix(input int n);
        int t, p, tx, ty;
        logic [7:0] x, y;
        logic [2:0] c;
        t = n / 25; p = n % 25; tx = t % W; ty = t / W;
        x = 8'(tx * 5 + p % 5);
        y = 8'(ty * 5 + p / 5);
        c = (mdl[t] && shp_exp[24 - p]) ? 3'b111 : 3'b000;
        return {x, y, c};
    endfunction

    task automatic refill();
        for (int i = 0; i < NT; i++) mdl[i] = 1'b1;
    endtask

    // Walk a pass: compare each transfer to the model and check stall hold.
    task automatic run_pass(input int maxn, input bit stall,
                            output int errs, output int cyc, output int n, output int dones);
        logic [18:0] held;
        bit stalled;
        held = '0; stalled = 0; errs = 0; cyc = 0; n = 0; dones = 0;
        while (n < maxn && cyc < 60000) begin
            @(negedge clock);
            start = 0; eat_valid = 0; frame_tick = 0; cyc++;
            if (done) dones++;
            if (stalled && {plot_x, plot_y, plot_colour} != held) errs++;
            plot_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (plot_valid && plot_ready) begin
                if ({plot_x, plot_y, plot_colour} != exp_pix(n)) errs++;
                got[n] = {plot_x, plot_y, plot_colour};
                n++;
            end
            held = {plot_x, plot_y, plot_colour};
            stalled = plot_valid && !plot_ready;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1; start = 0; eat_valid = 0; frame_tick = 0; plot_ready = 1;
        @(negedge clock);
        reset = 0;
        refill();
    endtask

    task automatic eat(input int x, input int y);
        @(negedge clock);
        eat_valid = 1; eat_x = 5'(x); eat_y = 5'(y);
        @(negedge clock);
        eat_valid = 0;
        if (x < W && y < H) mdl[y * W + x] = 1'b0;
    endtask

    initial begin
        eat_vec_t ev [6];
        pix_vec_t pv [8];
        int errs, cyc, n, dones;

        ev = '{'{3, 2, 867}, '{3, 2, 867}, '{30, 1, 867}, '{0, 31, 867},
               '{27, 30, 866}, '{5, 0, 865}};
        pv = '{'{0, 0, 0, 0}, '{6, 1, 1, 0}, '{7, 2, 1, 7}, '{12, 2, 2, 7},
               '{25, 5, 0, 0}, '{32, 7, 1, 7}, '{700, 0, 5, 0}, '{21699, 139, 154, 0}};
        refill();
        shp_exp = A0;

        // Reset values
        repeat (2) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_eat_ready", eat_ready, 1);
        check("rst_plot_valid", plot_valid, 0);
        check("rst_plot_xyc", {plot_x, plot_y, plot_colour}, 0);
        check("rst_left", pellets_left, 868);
        check("rst_all_eaten", all_eaten, 0);
        reset = 0;

        // Full pass, plot_ready high
        @(negedge clock);
        start = 1;
        run_pass(NPIX, 0, errs, cyc, n, dones);
        check("p1_xfers", n, NPIX);
        check("p1_seq_errs", errs, 0);
        check("p1_no_early_done", dones, 0);
        check("p1_eat_ready_busy", eat_ready, 0);
        @(negedge clock);
        check("p1_done_cycle", cyc + 1, 21701);
        check("p1_done", done, 1);
        check("p1_done_busy", busy, 0);
        check("p1_done_valid", plot_valid, 0);
        @(negedge clock);
        check("p1_done_pulse", done, 0);
        check("p1_idle_eat_ready", eat_ready, 1);
        for (int i = 0; i < 8; i++)
            check($sformatf("p1_pix%0d", pv[i].idx), int'(got[pv[i].idx]),
                  (pv[i].x << 11) | (pv[i].y << 3) | pv[i].c);

        // Eat vectors
        for (int i = 0; i < 6; i++) begin
            eat(ev[i].x, ev[i].y);
            check($sformatf("eat%0d_left", i), pellets_left, ev[i].left);
        end

        // Stalled pass over the first 64 tiles; covers eaten tiles (5,0),(3,2)
        @(negedge clock);
        start = 1;
        run_pass(1600, 1, errs, cyc, n, dones);
        check("p2_xfers", n, 1600);
        check("p2_seq_errs", errs, 0);
        check("p2_tile32_erased", int'(got[1475 + 7][2:0]), 0);
        check("p2_tile50_erased", int'(got[125 + 12][2:0]), 0);
        do_reset();
        check("p2_reset_left", pellets_left, 868);

        // Reset after 500 transfers
        eat(1, 1);
        check("p3_eat_left", pellets_left, 867);
        @(negedge clock);
        start = 1;
        run_pass(500, 0, errs, cyc, n, dones);
        check("p3_xfers", n, 500);
        @(negedge clock);
        reset = 1;
        @(negedge clock);
        reset = 0;
        refill();
        check("p3_rst_busy", busy, 0);
        check("p3_rst_valid", plot_valid, 0);
        check("p3_rst_xyc", {plot_x, plot_y, plot_colour}, 0);
        check("p3_rst_left", pellets_left, 868);
        check("p3_rst_done", done | dones, 0);
        @(negedge clock);
        check("p3_no_done_after", done, 0);

        // Two ticks then start: ANI_1 when animated
        repeat (2) begin
            @(negedge clock); frame_tick = 1;
            @(negedge clock); frame_tick = 0;
        end
        shp_exp = ANIM ? A1 : A0;
        start = 1;
        run_pass(8, 0, errs, cyc, n, dones);
        check("ani_two_ticks_pix6", int'(got[6][2:0]), ANIM ? 7 : 0);
        check("ani_two_ticks_errs", errs, 0);
        do_reset();

        // Start coincident with 2nd tick: pre-toggle phase (ANI_0)
        @(negedge clock); frame_tick = 1;
        @(negedge clock); frame_tick = 0;
        @(negedge clock); frame_tick = 1; start = 1;
        shp_exp = A0;
        run_pass(8, 0, errs, cyc, n, dones);
        check("ani_coinc_pix6", int'(got[6][2:0]), 0);
        check("ani_coinc_pix7", int'(got[7][2:0]), 7);
        do_reset();

        // start with eat (0,0) in the same cycle
        @(negedge clock);
        start = 1; eat_valid = 1; eat_x = 0; eat_y = 0;
        mdl[0] = 1'b0;
        run_pass(10, 0, errs, cyc, n, dones);
        check("se_pix7_erased", int'(got[7][2:0]), 0);
        check("se_errs", errs, 0);
        check("se_left", pellets_left, 867);
        do_reset();

        // Eat every tile, then one more
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                @(negedge clock);
                eat_valid = 1; eat_x = 5'(x); eat_y = 5'(y);
            end
        @(negedge clock);
        eat_valid = 0;
        check("all_left", pellets_left, 0);
        check("all_eaten", all_eaten, 1);
        eat(2, 2);
        check("all_left_sat", pellets_left, 0);
        check("all_eaten_hold", all_eaten, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
